// File: rtl/lane_deserializer_pkg.sv
// ---------------------------------------------------------------------------
// lane_pkg : shared widths, lane index type and FIFO default for the
//            4-lane deserializer.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package lane_pkg;

  localparam int LANES          = 4;
  localparam int WORD_W         = 4;
  localparam int FIFO_DEPTH_DEF = 4;

  // Index of a lane; wraps naturally mod 4.
  typedef logic [1:0] lane_idx_t;

  localparam lane_idx_t LAST_LANE = 2'd3;

  // Round-robin successor of a lane index.
  function automatic lane_idx_t lane_next(input lane_idx_t cur);
    return lane_idx_t'(cur + 2'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lane_deserializer_fifo.sv
// ---------------------------------------------------------------------------
// word_fifo4 : synchronous word FIFO with a registered head output.
//              Push into a full FIFO and pop from an empty FIFO are ignored.
// Revision   : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module word_fifo4
  import lane_pkg::*;
#(
  parameter int WORD_W_P   = WORD_W,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                push_i,
  input  logic [WORD_W_P-1:0] wdata_i,
  input  logic                pop_i,
  output logic                full_o,
  output logic                empty_o,
  output logic [WORD_W_P-1:0] head_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WORD_W_P-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_q, wr_d;
  logic [AW-1:0]       rd_q, rd_d;
  logic [CW-1:0]       count_q, count_d;
  logic [WORD_W_P-1:0] head_q, head_d;
  logic                do_push;
  logic                do_pop;

  assign full_o  = (count_q == CW'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = head_q;

  // Next pointers, occupancy and the word that will sit at the head.
  always_comb begin
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    wr_d    = wr_q + AW'(do_push);
    rd_d    = rd_q + AW'(do_pop);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
    head_d  = '0;
    if (count_d != '0) begin
      // The slot being written becomes the head only when nothing older remains.
      if (do_push && (wr_q == rd_d)) begin
        head_d = wdata_i;
      end else begin
        head_d = mem_q[rd_d];
      end
    end
  end

  // Pointer, occupancy and head registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  // Storage array; cleared on reset so no stale data survives.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/lane_deserializer.sv
// ---------------------------------------------------------------------------
// lane_deserializer : distributes a serial bitstream round-robin into 4 lanes,
//                     buffers completed words in a FIFO and flags runs of
//                     four consecutive ones.
// Revision          : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module lane_deserializer
  import lane_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_bit,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sync,
  output logic [WORD_W-1:0] out_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        SEL,
  output logic [3:0]        last4,
  output logic              consec4
);

  lane_idx_t         sel_q, sel_d;
  logic [LANES-2:0]  lanes_q, lanes_d;
  logic [3:0]        last4_q, last4_d;
  logic              accept;
  logic              push;
  logic              fifo_full;
  logic              fifo_empty;
  logic [WORD_W-1:0] push_word;

  // Only the lane3 bit can stall, and only when it has nowhere to go.
  assign in_ready  = !sync && !((sel_q == LAST_LANE) && fifo_full);
  assign accept    = in_valid && in_ready;
  assign push      = accept && (sel_q == LAST_LANE);
  assign push_word = {in_bit, lanes_q};

  assign SEL       = sel_q;
  assign last4     = last4_q;
  assign consec4   = &last4_q;
  assign out_valid = !fifo_empty;

  // Lane counter, partial word and history update.
  always_comb begin
    sel_d   = sel_q;
    lanes_d = lanes_q;
    last4_d = last4_q;
    if (sync) begin
      sel_d   = '0;
      lanes_d = '0;
      last4_d = '0;
    end else if (accept) begin
      case (sel_q)
        2'd0:    lanes_d[0] = in_bit;
        2'd1:    lanes_d[1] = in_bit;
        2'd2:    lanes_d[2] = in_bit;
        default: lanes_d    = lanes_q;
      endcase
      sel_d   = lane_next(sel_q);
      last4_d = {last4_q[2:0], in_bit};
    end
  end

  // State registers for framing and run detection.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sel_q   <= '0;
      lanes_q <= '0;
      last4_q <= '0;
    end else begin
      sel_q   <= sel_d;
      lanes_q <= lanes_d;
      last4_q <= last4_d;
    end
  end

  word_fifo4 #(
    .WORD_W_P   (WORD_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push_i  (push),
    .wdata_i (push_word),
    .pop_i   (out_ready),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (out_word)
  );

endmodule

`default_nettype wire

// File: tb/tb_lane_deserializer.sv
// ---------------------------------------------------------------------------
// tb_lane_deserializer : directed, table-driven bench for lane_deserializer.
// Revision             : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lane_deserializer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       in_bit;
  logic       in_valid;
  logic       in_ready;
  logic       sync;
  logic [3:0] out_word;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] SEL;
  logic [3:0] last4;
  logic       consec4;

  lane_deserializer #(.FIFO_DEPTH(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sync      (sync),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .SEL       (SEL),
    .last4     (last4),
    .consec4   (consec4)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       b;
    logic       v;
    logic       s;
    logic       r;
    logic [1:0] sel;
    logic       ov;
    logic [3:0] ow;
    logic [3:0] l4;
    logic       c4;
    logic       rdy;
  } vec_t;

  vec_t vecs[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic add(input logic b, v, s, r, input logic [1:0] sel, input logic ov,
                     input logic [3:0] ow, l4, input logic c4, rdy);
    vec_t t;
    t.b = b; t.v = v; t.s = s; t.r = r; t.sel = sel; t.ov = ov;
    t.ow = ow; t.l4 = l4; t.c4 = c4; t.rdy = rdy;
    vecs.push_back(t);
  endtask

  logic [3:0] words [5];

  initial begin
    RST = 1'b0; in_bit = 1'b0; in_valid = 1'b0; sync = 1'b0; out_ready = 1'b0;
    words[0] = 4'h3; words[1] = 4'hA; words[2] = 4'h5; words[3] = 4'hC; words[4] = 4'h9;

    // basic word 1,0,1,1
    add(1,1,0,1, 2'd1,0,4'h0,4'b0001,0,1);
    add(0,1,0,1, 2'd2,0,4'h0,4'b0010,0,1);
    add(1,1,0,1, 2'd3,0,4'h0,4'b0101,0,1);
    add(1,1,0,1, 2'd0,1,4'b1101,4'b1011,0,1);
    add(0,0,0,1, 2'd0,0,4'h0,4'b1011,0,1);
    add(1,1,1,1, 2'd0,0,4'h0,4'b0000,0,1);
    // run detect 1,1,1,0,1,1,1,1,0
    add(1,1,0,1, 2'd1,0,4'h0,4'b0001,0,1);
    add(1,1,0,1, 2'd2,0,4'h0,4'b0011,0,1);
    add(1,1,0,1, 2'd3,0,4'h0,4'b0111,0,1);
    add(0,1,0,1, 2'd0,1,4'b0111,4'b1110,0,1);
    add(1,1,0,1, 2'd1,0,4'h0,4'b1101,0,1);
    add(1,1,0,1, 2'd2,0,4'h0,4'b1011,0,1);
    add(1,1,0,1, 2'd3,0,4'h0,4'b0111,0,1);
    add(1,1,0,1, 2'd0,1,4'b1111,4'b1111,1,1);
    add(0,1,0,1, 2'd1,0,4'h0,4'b1110,0,1);
    // sync mid-word
    add(0,0,1,1, 2'd0,0,4'h0,4'b0000,0,1);
    add(1,1,0,1, 2'd1,0,4'h0,4'b0001,0,1);
    add(1,1,0,1, 2'd2,0,4'h0,4'b0011,0,1);
    add(1,1,1,1, 2'd0,0,4'h0,4'b0000,0,1);
    add(0,1,0,1, 2'd1,0,4'h0,4'b0000,0,1);
    add(0,1,0,1, 2'd2,0,4'h0,4'b0000,0,1);
    add(1,1,0,1, 2'd3,0,4'h0,4'b0001,0,1);
    add(0,1,0,1, 2'd0,1,4'b0100,4'b0010,0,1);
    add(0,0,0,1, 2'd0,0,4'h0,4'b0010,0,1);

    // reset held while inputs toggle
    repeat (5) begin
      @(negedge CLK);
      in_bit    = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      sync      = 1'($urandom_range(0, 1));
    end
    sync = 1'b0;
    #1;
    chk("rst_sel", {2'b00, SEL}, 4'h0);
    chk("rst_ovalid", {3'b000, out_valid}, 4'h0);
    chk("rst_oword", out_word, 4'h0);
    chk("rst_last4", last4, 4'h0);
    chk("rst_consec4", {3'b000, consec4}, 4'h0);
    chk("rst_inready", {3'b000, in_ready}, 4'h1);
    @(negedge CLK);
    in_valid = 1'b0; out_ready = 1'b1; RST = 1'b1;

    // table vectors
    foreach (vecs[i]) begin
      @(negedge CLK);
      in_bit = vecs[i].b; in_valid = vecs[i].v; sync = vecs[i].s; out_ready = vecs[i].r;
      @(posedge CLK);
      #1;
      in_valid = 1'b0; sync = 1'b0;
      #1;
      chk($sformatf("v%0d_sel", i), {2'b00, SEL}, {2'b00, vecs[i].sel});
      chk($sformatf("v%0d_ovalid", i), {3'b000, out_valid}, {3'b000, vecs[i].ov});
      if (vecs[i].ov) chk($sformatf("v%0d_oword", i), out_word, vecs[i].ow);
      chk($sformatf("v%0d_last4", i), last4, vecs[i].l4);
      chk($sformatf("v%0d_consec4", i), {3'b000, consec4}, {3'b000, vecs[i].c4});
      chk($sformatf("v%0d_inready", i), {3'b000, in_ready}, {3'b000, vecs[i].rdy});
    end

    // backpressure: 19 bits fill the FIFO (4 words) plus 3 lanes
    out_ready = 1'b0;
    for (int i = 0; i < 19; i++) begin
      @(negedge CLK);
      in_bit = words[i/4][i%4]; in_valid = 1'b1;
      #1;
      chk($sformatf("bp_rdy%0d", i), {3'b000, in_ready}, 4'h1);
      @(posedge CLK);
    end
    @(negedge CLK);
    in_bit = words[4][3]; in_valid = 1'b1;
    #1;
    chk("bp_stall_rdy", {3'b000, in_ready}, 4'h0);
    chk("bp_stall_sel", {2'b00, SEL}, 4'h3);
    @(posedge CLK);
    #1;
    chk("bp_held_sel", {2'b00, SEL}, 4'h3);
    chk("bp_head_valid", {3'b000, out_valid}, 4'h1);
    chk("bp_head0", out_word, words[0]);
    @(negedge CLK);
    out_ready = 1'b1;
    @(posedge CLK);
    #1;
    out_ready = 1'b0;
    #1;
    chk("bp_pop_rdy", {3'b000, in_ready}, 4'h1);
    chk("bp_head1", out_word, words[1]);
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    chk("bp_sel_wrap", {2'b00, SEL}, 4'h0);
    out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      @(negedge CLK);
      chk($sformatf("drain_v%0d", k), {3'b000, out_valid}, 4'h1);
      chk($sformatf("drain_w%0d", k), out_word, words[k]);
      @(posedge CLK);
    end
    @(negedge CLK);
    chk("drain_empty", {3'b000, out_valid}, 4'h0);

    // async reset with 2 words buffered and SEL=2
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      in_bit = 1'b1; in_valid = 1'b1;
      @(posedge CLK);
    end
    @(negedge CLK);
    in_valid = 1'b0;
    #1;
    chk("ar_pre_sel", {2'b00, SEL}, 4'h2);
    chk("ar_pre_ovalid", {3'b000, out_valid}, 4'h1);
    #1;
    RST = 1'b0;
    #1;
    chk("ar_sel", {2'b00, SEL}, 4'h0);
    chk("ar_ovalid", {3'b000, out_valid}, 4'h0);
    chk("ar_oword", out_word, 4'h0);
    chk("ar_last4", last4, 4'h0);
    chk("ar_consec4", {3'b000, consec4}, 4'h0);
    chk("ar_inready", {3'b000, in_ready}, 4'h1);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    chk("ar_post_ovalid", {3'b000, out_valid}, 4'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
